// File: rtl/vend_sequencer_if.sv
// rtl/vend_sequencer_if.sv - coin, vend and change handshake bundle for vend_sequencer
// Optional macro: VEND_CANCEL_EN adds the cancel signal.
// Signals:
//   coins[1:0]     coin event (01=1, 10=2, 11=5 units, 00=none)
//   new_state[3:0] next credit from state_transitions
//   cur_state[3:0] registered credit, fed back to state_transitions
//   coin_ready     coins accepted only while high
//   coin_reject    pulse: coin arrived while not ready
//   vend_req/ack   product dispenser handshake
//   chg_req/ack    change dispenser handshake, chg_coin 1 = 2-unit, 0 = 1-unit
//   fault          pulse: illegal new_state or vend timeout
//   done           pulse: transaction closed
//   cancel         refund request (VEND_CANCEL_EN only)
interface vend_sequencer_if;
    logic [1:0] coins;
    logic [3:0] new_state;
    logic [3:0] cur_state;
    logic       coin_ready;
    logic       coin_reject;
    logic       vend_req;
    logic       vend_ack;
    logic       chg_req;
    logic       chg_coin;
    logic       chg_ack;
    logic       fault;
    logic       done;
`ifdef VEND_CANCEL_EN
    logic       cancel;

    modport slave (
        input  coins, new_state, vend_ack, chg_ack, cancel,
        output cur_state, coin_ready, coin_reject, vend_req, chg_req, chg_coin, fault, done
    );
    modport master (
        output coins, new_state, vend_ack, chg_ack, cancel,
        input  cur_state, coin_ready, coin_reject, vend_req, chg_req, chg_coin, fault, done
    );
`else
    modport slave (
        input  coins, new_state, vend_ack, chg_ack,
        output cur_state, coin_ready, coin_reject, vend_req, chg_req, chg_coin, fault, done
    );
    modport master (
        output coins, new_state, vend_ack, chg_ack,
        input  cur_state, coin_ready, coin_reject, vend_req, chg_req, chg_coin, fault, done
    );
`endif
endinterface

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - credit register, vend handshake and greedy change payout FSM
// Optional macro: VEND_CANCEL_EN enables cancel (refund from IDLE without vending).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    vend_sequencer_if.slave (coins/new_state in, cur_state out, vend and change handshakes)
// Parameters:
//   ACK_TIMEOUT  VEND cycles without vend_ack before the vend is aborted and refunded
//   TMR_W        timeout counter width
module vend_sequencer #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TMR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    vend_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE, S_FINISH} state_t;

    localparam logic [3:0]       PRICE   = 4'd4;
    localparam logic [3:0]       MAX_CR  = 4'd8;
    localparam logic [TMR_W-1:0] TIMEOUT = TMR_W'(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    state_t           r_state,       w_state;
    logic [3:0]       r_cur_state,   w_cur_state;
    logic [3:0]       r_change_rem,  w_change_rem;
    logic [TMR_W-1:0] r_timer,       w_timer;
    logic             r_vend_req,    w_vend_req;
    logic             r_chg_req,     w_chg_req;
    logic             r_chg_coin,    w_chg_coin;
    logic             r_coin_ready,  w_coin_ready;
    logic             r_coin_reject, w_coin_reject;
    logic             r_fault,       w_fault;
    logic             r_done,        w_done;

    logic             w_coin_in;
    logic             w_cancel;
    logic [3:0]       w_pay;
    logic [3:0]       w_rem_dec;
    logic [TMR_W-1:0] w_timer_inc;

    assign w_coin_in   = (bus.coins != 2'b00);
`ifdef VEND_CANCEL_EN
    assign w_cancel    = bus.cancel;
`else
    assign w_cancel    = 1'b0;
`endif
    assign w_pay       = r_chg_coin ? 4'd2 : 4'd1;
    // Saturating so a corrupted remainder can never wrap into a huge payout.
    assign w_rem_dec   = (r_change_rem > w_pay) ? (r_change_rem - w_pay) : 4'd0;
    assign w_timer_inc = r_timer + TMR_ONE;

    always_comb begin
        w_state       = r_state;
        w_cur_state   = r_cur_state;
        w_change_rem  = r_change_rem;
        w_timer       = r_timer;
        w_vend_req    = r_vend_req;
        w_chg_req     = r_chg_req;
        w_chg_coin    = r_chg_coin;
        w_coin_reject = w_coin_in && !r_coin_ready;
        w_fault       = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_coin_in) begin
                    if (bus.new_state <= MAX_CR) begin
                        w_cur_state = bus.new_state;
                        if (bus.new_state >= PRICE) begin
                            w_change_rem = bus.new_state - PRICE;
                            w_timer      = '0;
                            w_vend_req   = 1'b1;
                            w_state      = S_VEND;
                        end
                    end else begin
                        w_fault = 1'b1;
                    end
                end else if (w_cancel && (r_cur_state != 4'd0)) begin
                    w_change_rem = r_cur_state;
                    w_chg_req    = 1'b1;
                    w_chg_coin   = (r_cur_state >= 4'd2);
                    w_state      = S_CHANGE;
                end
            end
            S_VEND: begin
                if (bus.vend_ack) begin
                    w_vend_req = 1'b0;
                    if (r_change_rem != 4'd0) begin
                        w_chg_req  = 1'b1;
                        w_chg_coin = (r_change_rem >= 4'd2);
                        w_state    = S_CHANGE;
                    end else begin
                        w_state = S_FINISH;
                    end
                end else if (w_timer_inc == TIMEOUT) begin
                    // Dispenser never answered: give back the whole credit.
                    w_timer      = w_timer_inc;
                    w_vend_req   = 1'b0;
                    w_change_rem = r_cur_state;
                    w_fault      = 1'b1;
                    w_chg_req    = 1'b1;
                    w_chg_coin   = (r_cur_state >= 4'd2);
                    w_state      = S_CHANGE;
                end else begin
                    w_timer = w_timer_inc;
                end
            end
            S_CHANGE: begin
                if (bus.chg_ack) begin
                    w_change_rem = w_rem_dec;
                    if (w_rem_dec == 4'd0) begin
                        w_chg_req  = 1'b0;
                        w_chg_coin = 1'b0;
                        w_state    = S_FINISH;
                    end else begin
                        w_chg_coin = (w_rem_dec >= 4'd2);
                    end
                end
            end
            S_FINISH: begin
                w_cur_state = 4'd0;
                w_done      = 1'b1;
                w_state     = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase

        w_coin_ready = (w_state == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cur_state   <= 4'd0;
            r_change_rem  <= 4'd0;
            r_timer       <= '0;
            r_vend_req    <= 1'b0;
            r_chg_req     <= 1'b0;
            r_chg_coin    <= 1'b0;
            r_coin_ready  <= 1'b1;
            r_coin_reject <= 1'b0;
            r_fault       <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cur_state   <= w_cur_state;
            r_change_rem  <= w_change_rem;
            r_timer       <= w_timer;
            r_vend_req    <= w_vend_req;
            r_chg_req     <= w_chg_req;
            r_chg_coin    <= w_chg_coin;
            r_coin_ready  <= w_coin_ready;
            r_coin_reject <= w_coin_reject;
            r_fault       <= w_fault;
            r_done        <= w_done;
        end
    end

    assign bus.cur_state   = r_cur_state;
    assign bus.coin_ready  = r_coin_ready;
    assign bus.coin_reject = r_coin_reject;
    assign bus.vend_req    = r_vend_req;
    assign bus.chg_req     = r_chg_req;
    assign bus.chg_coin    = r_chg_coin;
    assign bus.fault       = r_fault;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed self-checking bench for vend_sequencer
module tb_vend_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vend_sequencer_if vif();

    logic       force_en = 1'b0;
    logic [3:0] force_ns = 4'd0;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [3:0] coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return 4'd1;
            2'b10:   return 4'd2;
            2'b11:   return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    // Stand-in for state_transitions: credit plus coin value.
    assign vif.new_state = force_en ? force_ns : (vif.cur_state + coin_units(vif.coins));

    vend_sequencer #(.ACK_TIMEOUT(255), .TMR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic insert_coin(input logic [1:0] c);
        vif.coins = c;
        step();
        vif.coins = 2'b00;
    endtask

    task automatic run_change(output int units, output int ncoins, output logic [7:0] pat);
        units = 0; ncoins = 0; pat = 8'd0;
        for (int k = 0; k < 20; k++) begin
            if (!vif.chg_req) break;
            units  = units + (vif.chg_coin ? 2 : 1);
            ncoins = ncoins + 1;
            pat    = {pat[6:0], vif.chg_coin};
            vif.chg_ack = 1'b1;
            step();
            vif.chg_ack = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20; k++) begin
            if (vif.done) break;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_checks++;
        if ({vif.cur_state, vif.coin_ready, vif.coin_reject, vif.vend_req, vif.chg_req,
             vif.chg_coin, vif.fault, vif.done} !== {4'd0, 7'b1000000}) begin
            n_fail++;
            $display("FAIL reset_state: got cs=%0d rdy=%b rej=%b vreq=%b creq=%b ccoin=%b flt=%b done=%b required cs=0 rdy=1 others 0",
                     vif.cur_state, vif.coin_ready, vif.coin_reject, vif.vend_req, vif.chg_req,
                     vif.chg_coin, vif.fault, vif.done);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_exact_price();
        int vcnt;
        for (int i = 1; i <= 4; i++) begin
            insert_coin(2'b01);
            n_checks++;
            if (vif.cur_state !== 4'(i)) begin
                n_fail++; $display("FAIL exact_credit_%0d: cur_state=%0d required %0d", i, vif.cur_state, i);
            end
        end
        n_checks++;
        if (vif.vend_req !== 1'b1 || vif.coin_ready !== 1'b0) begin
            n_fail++; $display("FAIL exact_vend_start: vend_req=%b coin_ready=%b required 1 0", vif.vend_req, vif.coin_ready);
        end
        vcnt = 0;
        for (int k = 0; k < 3; k++) begin
            vcnt = vcnt + int'(vif.vend_req);
            if (k == 2) vif.vend_ack = 1'b1;
            step();
        end
        vif.vend_ack = 1'b0;
        n_checks++;
        if (vcnt != 3 || vif.vend_req !== 1'b0 || vif.chg_req !== 1'b0) begin
            n_fail++; $display("FAIL exact_vend_ack: vend_req cycles=%0d vend_req=%b chg_req=%b required 3 0 0", vcnt, vif.vend_req, vif.chg_req);
        end
        wait_done();
        n_checks++;
        if (vif.done !== 1'b1 || vif.cur_state !== 4'd0 || vif.coin_ready !== 1'b1) begin
            n_fail++; $display("FAIL exact_done: done=%b cur_state=%0d coin_ready=%b required 1 0 1", vif.done, vif.cur_state, vif.coin_ready);
        end
        step();
        n_checks++;
        if (vif.done !== 1'b0) begin
            n_fail++; $display("FAIL exact_done_pulse: done=%b required 0", vif.done);
        end
    endtask

    task automatic test_change_8();
        int units, ncoins; logic [7:0] pat;
        insert_coin(2'b01); insert_coin(2'b01); insert_coin(2'b01);
        insert_coin(2'b11);
        n_checks++;
        if (vif.cur_state !== 4'd8 || vif.vend_req !== 1'b1) begin
            n_fail++; $display("FAIL chg8_vend: cur_state=%0d vend_req=%b required 8 1", vif.cur_state, vif.vend_req);
        end
        vif.vend_ack = 1'b1; step(); vif.vend_ack = 1'b0;
        n_checks++;
        if (vif.chg_req !== 1'b1 || vif.chg_coin !== 1'b1 || vif.vend_req !== 1'b0 || vif.cur_state !== 4'd8) begin
            n_fail++; $display("FAIL chg8_start: chg_req=%b chg_coin=%b vend_req=%b cur_state=%0d required 1 1 0 8",
                               vif.chg_req, vif.chg_coin, vif.vend_req, vif.cur_state);
        end
        run_change(units, ncoins, pat);
        n_checks++;
        if (units != 4 || ncoins != 2 || pat !== 8'b0000_0011 || vif.chg_coin !== 1'b0) begin
            n_fail++; $display("FAIL chg8_payout: units=%0d coins=%0d pattern=%b chg_coin=%b required 4 2 00000011 0",
                               units, ncoins, pat, vif.chg_coin);
        end
        wait_done();
        n_checks++;
        if (vif.done !== 1'b1 || vif.cur_state !== 4'd0) begin
            n_fail++; $display("FAIL chg8_done: done=%b cur_state=%0d required 1 0", vif.done, vif.cur_state);
        end
    endtask

    task automatic test_timeout();
        int units, ncoins, vcnt; logic [7:0] pat;
        insert_coin(2'b10);
        insert_coin(2'b10);
        n_checks++;
        if (vif.cur_state !== 4'd4 || vif.vend_req !== 1'b1) begin
            n_fail++; $display("FAIL tmo_vend: cur_state=%0d vend_req=%b required 4 1", vif.cur_state, vif.vend_req);
        end
        vcnt = 0;
        while (vif.vend_req && vcnt < 400) begin
            vcnt++;
            step();
        end
        n_checks++;
        if (vcnt != 255) begin
            n_fail++; $display("FAIL tmo_length: vend_req cycles=%0d required 255", vcnt);
        end
        n_checks++;
        if (vif.fault !== 1'b1 || vif.chg_req !== 1'b1 || vif.chg_coin !== 1'b1 || vif.cur_state !== 4'd4) begin
            n_fail++; $display("FAIL tmo_refund_start: fault=%b chg_req=%b chg_coin=%b cur_state=%0d required 1 1 1 4",
                               vif.fault, vif.chg_req, vif.chg_coin, vif.cur_state);
        end
        step();
        n_checks++;
        if (vif.fault !== 1'b0) begin
            n_fail++; $display("FAIL tmo_fault_pulse: fault=%b required 0", vif.fault);
        end
        run_change(units, ncoins, pat);
        n_checks++;
        if (units != 4 || ncoins != 2 || pat !== 8'b0000_0011) begin
            n_fail++; $display("FAIL tmo_payout: units=%0d coins=%0d pattern=%b required 4 2 00000011", units, ncoins, pat);
        end
        wait_done();
        n_checks++;
        if (vif.done !== 1'b1 || vif.cur_state !== 4'd0) begin
            n_fail++; $display("FAIL tmo_done: done=%b cur_state=%0d required 1 0", vif.done, vif.cur_state);
        end
    endtask

    task automatic test_reject_in_vend();
        int units, ncoins; logic [7:0] pat;
        insert_coin(2'b11);
        insert_coin(2'b01);
        n_checks++;
        if (vif.coin_reject !== 1'b1 || vif.cur_state !== 4'd5 || vif.vend_req !== 1'b1) begin
            n_fail++; $display("FAIL rej_pulse: coin_reject=%b cur_state=%0d vend_req=%b required 1 5 1",
                               vif.coin_reject, vif.cur_state, vif.vend_req);
        end
        step();
        n_checks++;
        if (vif.coin_reject !== 1'b0) begin
            n_fail++; $display("FAIL rej_one_cycle: coin_reject=%b required 0", vif.coin_reject);
        end
        vif.vend_ack = 1'b1; step(); vif.vend_ack = 1'b0;
        n_checks++;
        if (vif.chg_req !== 1'b1 || vif.chg_coin !== 1'b0 || vif.cur_state !== 4'd5) begin
            n_fail++; $display("FAIL rej_change: chg_req=%b chg_coin=%b cur_state=%0d required 1 0 5",
                               vif.chg_req, vif.chg_coin, vif.cur_state);
        end
        run_change(units, ncoins, pat);
        n_checks++;
        if (units != 1 || ncoins != 1) begin
            n_fail++; $display("FAIL rej_payout: units=%0d coins=%0d required 1 1", units, ncoins);
        end
        wait_done();
        n_checks++;
        if (vif.done !== 1'b1 || vif.cur_state !== 4'd0) begin
            n_fail++; $display("FAIL rej_done: done=%b cur_state=%0d required 1 0", vif.done, vif.cur_state);
        end
    endtask

    task automatic test_illegal_state();
        insert_coin(2'b10);
        force_en = 1'b1; force_ns = 4'd12;
        insert_coin(2'b01);
        force_en = 1'b0;
        n_checks++;
        if (vif.fault !== 1'b1 || vif.cur_state !== 4'd2 || vif.coin_ready !== 1'b1 || vif.vend_req !== 1'b0) begin
            n_fail++; $display("FAIL illegal_fault: fault=%b cur_state=%0d coin_ready=%b vend_req=%b required 1 2 1 0",
                               vif.fault, vif.cur_state, vif.coin_ready, vif.vend_req);
        end
        step();
        n_checks++;
        if (vif.fault !== 1'b0 || vif.cur_state !== 4'd2) begin
            n_fail++; $display("FAIL illegal_pulse: fault=%b cur_state=%0d required 0 2", vif.fault, vif.cur_state);
        end
    endtask

    task automatic test_reset_mid_change();
        insert_coin(2'b11);
        vif.vend_ack = 1'b1; step(); vif.vend_ack = 1'b0;
        n_checks++;
        if (vif.chg_req !== 1'b1 || vif.chg_coin !== 1'b1 || vif.cur_state !== 4'd7) begin
            n_fail++; $display("FAIL rst_mid_setup: chg_req=%b chg_coin=%b cur_state=%0d required 1 1 7",
                               vif.chg_req, vif.chg_coin, vif.cur_state);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (vif.chg_req !== 1'b0 || vif.cur_state !== 4'd0 || vif.coin_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_async: chg_req=%b cur_state=%0d coin_ready=%b required 0 0 1",
                               vif.chg_req, vif.cur_state, vif.coin_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (vif.chg_req !== 1'b0 || vif.coin_ready !== 1'b1 || vif.vend_req !== 1'b0 || vif.cur_state !== 4'd0) begin
            n_fail++; $display("FAIL rst_mid_release: chg_req=%b coin_ready=%b vend_req=%b cur_state=%0d required 0 1 0 0",
                               vif.chg_req, vif.coin_ready, vif.vend_req, vif.cur_state);
        end
        insert_coin(2'b01);
        n_checks++;
        if (vif.cur_state !== 4'd1 || vif.chg_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_resume: cur_state=%0d chg_req=%b required 1 0", vif.cur_state, vif.chg_req);
        end
    endtask

`ifdef VEND_CANCEL_EN
    task automatic test_cancel();
        int units, ncoins; logic [7:0] pat;
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        insert_coin(2'b10);
        insert_coin(2'b01);
        vif.cancel = 1'b1; step(); vif.cancel = 1'b0;
        n_checks++;
        if (vif.chg_req !== 1'b1 || vif.chg_coin !== 1'b1 || vif.vend_req !== 1'b0 || vif.cur_state !== 4'd3) begin
            n_fail++; $display("FAIL cancel_start: chg_req=%b chg_coin=%b vend_req=%b cur_state=%0d required 1 1 0 3",
                               vif.chg_req, vif.chg_coin, vif.vend_req, vif.cur_state);
        end
        run_change(units, ncoins, pat);
        n_checks++;
        if (units != 3 || ncoins != 2 || pat !== 8'b0000_0010) begin
            n_fail++; $display("FAIL cancel_payout: units=%0d coins=%0d pattern=%b required 3 2 00000010", units, ncoins, pat);
        end
        wait_done();
        n_checks++;
        if (vif.done !== 1'b1 || vif.cur_state !== 4'd0) begin
            n_fail++; $display("FAIL cancel_done: done=%b cur_state=%0d required 1 0", vif.done, vif.cur_state);
        end
        step();
        vif.cancel = 1'b1; step(); vif.cancel = 1'b0;
        n_checks++;
        if (vif.chg_req !== 1'b0 || vif.coin_ready !== 1'b1) begin
            n_fail++; $display("FAIL cancel_zero_ignored: chg_req=%b coin_ready=%b required 0 1", vif.chg_req, vif.coin_ready);
        end
    endtask
`endif

    initial begin
        vif.coins    = 2'b00;
        vif.vend_ack = 1'b0;
        vif.chg_ack  = 1'b0;
`ifdef VEND_CANCEL_EN
        vif.cancel   = 1'b0;
`endif
        test_reset();
        test_exact_price();
        test_change_8();
        test_timeout();
        test_reject_in_vend();
        test_illegal_state();
        test_reset_mid_change();
`ifdef VEND_CANCEL_EN
        test_cancel();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 500000");
        $fatal(1, "watchdog");
    end
endmodule
